// File: rtl/rr_arb_mux_pkg.sv
// Shared defaults and the arbitration mode encoding for the round-robin arbiter/mux.
package rr_arb_mux_pkg;

  localparam int DEFAULT_N_CH   = 4;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic {
    MODE_RR  = 1'b0,
    MODE_SEL = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot grant: rotating-priority search from ptr, or a forced one-hot select.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter  int N_CH  = DEFAULT_N_CH,
  localparam int PTR_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  mode_e            mode,
  input  logic [N_CH-1:0]  sel,
  output logic [N_CH-1:0]  grant
);

  logic [N_CH-1:0]  rr_grant;
  logic [N_CH-1:0]  sel_grant;
  logic [PTR_W-1:0] idx;
  logic             found;

  // First requester at or above ptr, wrapping past the top channel.
  always_comb begin
    rr_grant = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N_CH);
      if (!found && req[idx]) begin
        rr_grant[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  // A malformed select (zero or several bits) simply grants nobody.
  assign sel_grant = $onehot(sel) ? (sel & req) : '0;
  assign grant     = (mode == MODE_SEL) ? sel_grant : rr_grant;

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated mux feeding a single registered output stage with valid/ready handshake.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int N_CH   = DEFAULT_N_CH,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [N_CH-1:0]          sel,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [N_CH-1:0]          out_grant,
  input  logic                     out_ready
);

  localparam int PTR_W = $clog2(N_CH);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [N_CH-1:0]   out_grant_q, out_grant_d;

  logic [N_CH-1:0]   grant;
  logic [N_CH-1:0]   take;
  logic              can_accept;
  logic              xfer;
  logic [DATA_W-1:0] ch_data [N_CH];
  logic [DATA_W-1:0] win_data;
  logic [PTR_W-1:0]  win_next;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_slice
    assign ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req   (in_valid),
    .ptr   (ptr_q),
    .mode  (mode_e'(mode)),
    .sel   (sel),
    .grant (grant)
  );

  // The output register can take a word when empty or when it is being drained this cycle.
  assign can_accept = ~out_valid_q | out_ready;
  assign in_ready   = rst ? '0 : (grant & {N_CH{can_accept}});
  assign take       = in_valid & in_ready;
  assign xfer       = |take;

  always_comb begin
    win_data = '0;
    win_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        win_data = win_data | ch_data[i];
        win_next = PTR_W'((i + 1) % N_CH);
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_grant_d = out_grant_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_grant_d = grant;
      if (mode_e'(mode) == MODE_RR) begin
        ptr_d = win_next;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_grant_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_grant_q <= out_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_grant = out_grant_q;

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, data width per channel.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mode  input  1  0 = round-robin arbitration, 1 = forced one-hot select.
REQ-006 SHALL have port sel  input  N_CH  one-hot channel select, used only when mode=1.
REQ-007 SHALL have port in_valid  input  N_CH  per-channel request.
REQ-008 SHALL have port in_data  input  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port in_ready  output  N_CH  per-channel accept; at most one bit high per cycle.
REQ-010 SHALL have port out_valid  output  1  output register holds a word.
REQ-011 SHALL have port out_data  output  DATA_W  registered selected word.
REQ-012 SHALL have port out_grant  output  N_CH  one-hot source channel of out_data.
REQ-013 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-014 SHALL compute combinational one-hot grant g each cycle; transfer on channel i occurs when in_valid[i] & in_ready[i].
REQ-015 SHALL drive in_ready[i] = g[i] & (~out_valid | out_ready); no combinational path from in_valid[j] to in_ready[i] for j != i, other than via g.
REQ-016 Mode 0: g SHALL select the first requesting channel at or after pointer ptr, searching upward with wrap from N_CH-1 to 0.
REQ-017 Mode 0: on each transfer from channel k, ptr SHALL become (k+1) mod N_CH; ptr SHALL be unchanged on cycles without transfer.
REQ-018 Mode 1: g SHALL equal sel & in_valid when sel has exactly one bit set; otherwise g SHALL be 0 (no transfer, no error state); ptr SHALL be unchanged.
REQ-019 On transfer, SHALL load out_data with the granted word, out_grant with g, and set out_valid=1 at the next edge (latency 1 cycle).
REQ-020 When out_valid & out_ready and no transfer, SHALL clear out_valid next cycle; out_data and out_grant hold their last values.
REQ-021 When out_valid & ~out_ready, out_data, out_grant and out_valid SHALL hold stable, all in_ready SHALL be 0.
REQ-022 Simultaneous out_ready drain and new transfer SHALL sustain one word per cycle with out_valid staying 1.
REQ-023 Mode change SHALL take effect in the same cycle for g; a word already in the output register SHALL be unaffected.
REQ-024 No input word SHALL be dropped or duplicated: each accepted transfer appears exactly once on out_data with out_valid & out_ready.

Reset
REQ-025 On rst=1 at a clock edge, out_valid SHALL be 0, out_data SHALL be 0, out_grant SHALL be 0, ptr SHALL be 0.
REQ-026 During rst=1, all in_ready SHALL be 0; reset mid-transfer SHALL discard the held word.
REQ-027 First cycle after reset with all channels requesting in mode 0 SHALL grant channel 0.

Structure
REQ-028 Package rr_arb_mux_pkg SHALL hold default N_CH, default DATA_W and a mode enum (MODE_RR, MODE_SEL).
REQ-029 Grant logic SHALL be a sub-module rr_arbiter (inputs req, ptr, mode, sel; output one-hot grant); rr_arb_mux SHALL instantiate exactly one.
REQ-030 Pointer width SHALL be $clog2(N_CH); output register and ptr SHALL be the only state.

Verification
REQ-031 Reset, mode 0, in_valid=4'b1111, out_ready=1, data ch i = 32'hA0+i -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles, out_grant 0001,0010,0100,1000,0001.
REQ-032 Mode 0, only ch2 valid with 32'hDEADBEEF, out_ready=0 for 3 cycles -> one transfer, out_data held 3 cycles, in_ready=0 while stalled, released on out_ready=1.
REQ-033 Mode 1, sel=4'b0100, all valid -> only ch2 accepted every cycle; sel=4'b0110 or 4'b0000 -> in_ready=0, out_valid falls after drain.
REQ-034 Mode 0, ptr=3 after ch2 transfer, requests on ch1 and ch3 -> ch3 granted first, then ch1 (wrap).
REQ-035 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_grant=0; no stale word emitted.
REQ-036 Random valid/ready with N_CH=8, DATA_W=16 -> scoreboard confirms REQ-024 and per-channel in-order delivery.
